plb_lookup_stage: RTL and testbench

PLB_LOOKUP_STAGE -- requirements
Module: plb_lookup_stage

---
 rtl/plb_lookup_if.sv | 28 ++
 rtl/plb_lookup_stage.sv | 196 +++++++++++++++++++
 tb/tb_plb_lookup_stage.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/plb_lookup_if.sv
// Handshake bundle for the PLB lookup stage: one request channel from the
// issue stage, a hit response channel and a miss channel to the table walker.
interface plb_lookup_if #(
    parameter int ID_WIDTH  = 4,
    parameter int REQ_WIDTH = ID_WIDTH + 34
);
    logic                 s_valid_i;
    logic                 s_ready_o;
    logic [REQ_WIDTH-1:0] s_data_i;
    logic                 hit_valid_o;
    logic                 hit_ready_i;
    logic [ID_WIDTH:0]    hit_data_o;
    logic                 miss_valid_o;
    logic                 miss_ready_i;
    logic [REQ_WIDTH-1:0] miss_data_o;

    // Lookup stage side
    modport slave (
        input  s_valid_i, s_data_i, hit_ready_i, miss_ready_i,
        output s_ready_o, hit_valid_o, hit_data_o, miss_valid_o, miss_data_o
    );

    // Environment side (issue stage + response consumers)
    modport master (
        output s_valid_i, s_data_i, hit_ready_i, miss_ready_i,
        input  s_ready_o, hit_valid_o, hit_data_o, miss_valid_o, miss_data_o
    );
endinterface

// File: rtl/plb_lookup_stage.sv
// Fully-associative permission lookaside buffer lookup stage.
// Request {id, addr[31:0], acc[1:0]} is matched on addr[31:12]; a hit returns
// {id, allow}, a miss forwards the request unchanged to the table walker.
// One output register serves both response channels, so only one of them is
// ever valid. Optional statistics counters are enabled by MPT_PLB_STATS_EN.
module plb_lookup_stage #(
    parameter int ID_WIDTH    = 4,
    parameter int PLB_ENTRIES = 8,
    parameter int REQ_WIDTH   = ID_WIDTH + 34
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    plb_lookup_if.slave bus,
    input  logic        refill_valid_i,
    input  logic [19:0] refill_ppn_i,
    input  logic [2:0]  refill_perm_i,
    input  logic        flush_i,
    output logic [31:0] hit_count_o,
    output logic [31:0] miss_count_o
);
    localparam int IDX_W = (PLB_ENTRIES > 1) ? $clog2(PLB_ENTRIES) : 1;

    localparam logic [1:0] IDLE      = 2'b00;
    localparam logic [1:0] HIT_HOLD  = 2'b01;
    localparam logic [1:0] MISS_HOLD = 2'b10;

    logic [1:0]                   state_q, state_d;
    logic [REQ_WIDTH-1:0]         out_q, out_d;
    logic [PLB_ENTRIES-1:0]       valid_q, valid_d;
    logic [PLB_ENTRIES-1:0][19:0] ppn_q, ppn_d;
    logic [PLB_ENTRIES-1:0][2:0]  perm_q, perm_d;
    logic [IDX_W-1:0]             victim_q, victim_d;

    logic [1:0]          req_acc;
    logic [19:0]         req_vpn;
    logic [ID_WIDTH-1:0] req_id;
    logic                accept;
    logic                lk_hit;
    logic [2:0]          lk_perm;
    logic                allow;

    logic                rf_match, rf_free;
    logic [IDX_W-1:0]    rf_match_idx, rf_free_idx;

    assign req_acc = bus.s_data_i[1:0];
    assign req_vpn = bus.s_data_i[33:14];
    assign req_id  = bus.s_data_i[REQ_WIDTH-1:34];

    assign bus.s_ready_o = (state_q == IDLE)
                         || ((state_q == HIT_HOLD)  && bus.hit_ready_i)
                         || ((state_q == MISS_HOLD) && bus.miss_ready_i);
    assign accept = bus.s_valid_i && bus.s_ready_o;

    assign bus.hit_valid_o  = (state_q == HIT_HOLD);
    assign bus.miss_valid_o = (state_q == MISS_HOLD);
    assign bus.hit_data_o   = bus.hit_valid_o  ? out_q[ID_WIDTH:0] : '0;
    assign bus.miss_data_o  = bus.miss_valid_o ? out_q : '0;

    // Associative compare of the incoming page against all valid entries;
    // refills keep tags unique, so OR-ing the matching perms is a clean select.
    always_comb begin
        lk_hit  = 1'b0;
        lk_perm = 3'b000;
        for (int i = 0; i < PLB_ENTRIES; i++) begin
            if (valid_q[i] && (ppn_q[i] == req_vpn)) begin
                lk_hit  = 1'b1;
                lk_perm = lk_perm | perm_q[i];
            end
        end
    end

    // Permission bit select by access type: r, w, x; acc=11 is always denied
    always_comb begin
        case (req_acc)
            2'b00:   allow = lk_perm[0];
            2'b01:   allow = lk_perm[1];
            2'b10:   allow = lk_perm[2];
            default: allow = 1'b0;
        endcase
    end

    // Response FSM; an accepted request always overwrites the held result,
    // which gives back-to-back throughput when the consumer is ready.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        if (accept) begin
            if ((req_acc == 2'b11) || lk_hit) begin
                state_d           = HIT_HOLD;
                out_d             = '0;
                out_d[ID_WIDTH:0] = {req_id, (req_acc != 2'b11) && allow};
            end else begin
                state_d = MISS_HOLD;
                out_d   = bus.s_data_i;
            end
        end else if (((state_q == HIT_HOLD) && bus.hit_ready_i)
                  || ((state_q == MISS_HOLD) && bus.miss_ready_i)) begin
            state_d = IDLE;
        end
    end

    // Refill slot search: existing tag first, then lowest free slot
    always_comb begin
        rf_match     = 1'b0;
        rf_match_idx = '0;
        rf_free      = 1'b0;
        rf_free_idx  = '0;
        for (int i = PLB_ENTRIES - 1; i >= 0; i--) begin
            if (valid_q[i] && (ppn_q[i] == refill_ppn_i)) begin
                rf_match     = 1'b1;
                rf_match_idx = IDX_W'(i);
            end
            if (!valid_q[i]) begin
                rf_free     = 1'b1;
                rf_free_idx = IDX_W'(i);
            end
        end
    end

    // Entry array update; flush takes precedence and drops a same-cycle refill
    always_comb begin
        valid_d  = valid_q;
        ppn_d    = ppn_q;
        perm_d   = perm_q;
        victim_d = victim_q;
        if (flush_i) begin
            valid_d  = '0;
            victim_d = '0;
        end else if (refill_valid_i) begin
            if (rf_match) begin
                perm_d[rf_match_idx] = refill_perm_i;
            end else if (rf_free) begin
                valid_d[rf_free_idx] = 1'b1;
                ppn_d[rf_free_idx]   = refill_ppn_i;
                perm_d[rf_free_idx]  = refill_perm_i;
            end else begin
                ppn_d[victim_q]  = refill_ppn_i;
                perm_d[victim_q] = refill_perm_i;
                victim_d         = victim_q + 1'b1;
            end
        end
    end

    // State, output register and entry array
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            out_q    <= '0;
            valid_q  <= '0;
            ppn_q    <= '0;
            perm_q   <= '0;
            victim_q <= '0;
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            valid_q  <= valid_d;
            ppn_q    <= ppn_d;
            perm_q   <= perm_d;
            victim_q <= victim_d;
        end
    end

`ifdef MPT_PLB_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

    // Saturating hit/miss counters; denied (acc=11) requests count as neither
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (accept && (req_acc != 2'b11)) begin
            if (lk_hit) begin
                if (hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_d = hit_cnt_q + 32'd1;
            end else begin
                if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_d = miss_cnt_q + 32'd1;
            end
        end
    end

    // Counter registers survive flush, cleared only by reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_count_o  = hit_cnt_q;
    assign miss_count_o = miss_cnt_q;
`else
    assign hit_count_o  = '0;
    assign miss_count_o = '0;
`endif
endmodule

// File: tb/tb_plb_lookup_stage.sv
// Directed bench for plb_lookup_stage: cold miss, refill/hit permissions,
// backpressure with back-to-back acceptance, replacement, flush race,
// held output under flush, statistics and reset mid-transaction.
module tb_plb_lookup_stage;
    localparam int IDW  = 4;
    localparam int REQW = IDW + 34;
    localparam int K_MISS = 0, K_HIT = 1, K_DENY = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        refill_valid = 1'b0;
    logic [19:0] refill_ppn = '0;
    logic [2:0]  refill_perm = '0;
    logic        flush = 1'b0;
    logic [31:0] hit_count, miss_count;

    int total = 0;
    int passed = 0;
    int exp_hits = 0;
    int exp_misses = 0;
    logic [REQW-1:0] held;

    always #5 clk = ~clk;

    plb_lookup_if #(.ID_WIDTH(IDW), .REQ_WIDTH(REQW)) bus ();

    plb_lookup_stage #(.ID_WIDTH(IDW), .PLB_ENTRIES(8), .REQ_WIDTH(REQW)) u_dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .bus            (bus),
        .refill_valid_i (refill_valid),
        .refill_ppn_i   (refill_ppn),
        .refill_perm_i  (refill_perm),
        .flush_i        (flush),
        .hit_count_o    (hit_count),
        .miss_count_o   (miss_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request for one cycle and check the registered result
    task automatic send(input string tag, input logic [IDW-1:0] id, input logic [31:0] addr,
                        input logic [1:0] acc, input int kind, input logic allow);
        logic [REQW-1:0] req;
        logic [IDW:0]    hexp;
        req = {id, addr, acc};
        bus.s_valid_i = 1'b1;
        bus.s_data_i  = req;
        step();
        bus.s_valid_i = 1'b0;
        if (kind == K_MISS) begin
            chk({tag, ".miss_valid"}, 64'(bus.miss_valid_o), 64'd1);
            chk({tag, ".hit_valid"},  64'(bus.hit_valid_o),  64'd0);
            chk({tag, ".miss_data"},  64'(bus.miss_data_o),  64'(req));
            exp_misses++;
        end else begin
            hexp = {id, allow};
            chk({tag, ".hit_valid"},  64'(bus.hit_valid_o),  64'd1);
            chk({tag, ".miss_valid"}, 64'(bus.miss_valid_o), 64'd0);
            chk({tag, ".hit_data"},   64'(bus.hit_data_o),   64'(hexp));
            if (kind == K_HIT) exp_hits++;
        end
    endtask

    task automatic refill(input logic [19:0] ppn, input logic [2:0] perm);
        refill_valid = 1'b1;
        refill_ppn   = ppn;
        refill_perm  = perm;
        step();
        refill_valid = 1'b0;
    endtask

    initial begin
        bus.s_valid_i    = 1'b0;
        bus.s_data_i     = '0;
        bus.hit_ready_i  = 1'b1;
        bus.miss_ready_i = 1'b1;

        // Reset state
        #12;
        chk("rst.hit_valid",  64'(bus.hit_valid_o),  64'd0);
        chk("rst.miss_valid", 64'(bus.miss_valid_o), 64'd0);
        chk("rst.hit_data",   64'(bus.hit_data_o),   64'd0);
        chk("rst.miss_data",  64'(bus.miss_data_o),  64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("rst.s_ready", 64'(bus.s_ready_o), 64'd1);
        chk("rst.hit_cnt", 64'(hit_count), 64'd0);

        // Cold miss
        send("cold", 4'd3, 32'h0000_5000, 2'b00, K_MISS, 1'b0);

        // Refill r/w page, then read, write, execute, denied access type
        refill(20'h00005, 3'b011);
        send("rd",   4'd1, 32'h0000_5ABC, 2'b00, K_HIT,  1'b1);
        send("wr",   4'd2, 32'h0000_5ABC, 2'b01, K_HIT,  1'b1);
        send("ex",   4'd4, 32'h0000_5ABC, 2'b10, K_HIT,  1'b0);
        send("deny", 4'd7, 32'h0000_5ABC, 2'b11, K_DENY, 1'b0);
        send("deny_miss", 4'd8, 32'h0000_9000, 2'b11, K_DENY, 1'b0);

        // Backpressure: result held, no acceptance, then same-cycle accept on release
        send("bp", 4'd5, 32'h0000_5000, 2'b00, K_HIT, 1'b1);
        bus.hit_ready_i = 1'b0;
        bus.s_valid_i   = 1'b1;
        bus.s_data_i    = {4'd6, 32'h0000_5004, 2'b01};
        for (int c = 0; c < 5; c++) begin
            step();
            chk("bp.hold_data", 64'(bus.hit_data_o), 64'({4'd5, 1'b1}));
            chk("bp.s_ready",   64'(bus.s_ready_o),  64'd0);
        end
        bus.hit_ready_i = 1'b1;
        #1;
        chk("bp.release_ready", 64'(bus.s_ready_o), 64'd1);
        step();
        bus.s_valid_i = 1'b0;
        chk("bp.next_valid", 64'(bus.hit_valid_o), 64'd1);
        chk("bp.next_data",  64'(bus.hit_data_o),  64'({4'd6, 1'b1}));
        exp_hits++;
        step();
        chk("bp.idle", 64'(bus.hit_valid_o), 64'd0);

        // Replacement: fill all 8, a 9th evicts entry 0 (ppn 0x10)
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int i = 0; i < 8; i++) refill(20'h00010 + 20'(i), 3'b001);
        refill(20'h00018, 3'b001);
        send("evicted", 4'd1, 32'h0001_0000, 2'b00, K_MISS, 1'b0);
        send("new",     4'd2, 32'h0001_8000, 2'b00, K_HIT,  1'b1);
        send("kept",    4'd3, 32'h0001_1000, 2'b00, K_HIT,  1'b1);
        // Update in place of a non-victim entry; victim (ppn 0x11) must survive
        refill(20'h00013, 3'b010);
        send("upd.wr",  4'd4, 32'h0001_3000, 2'b01, K_HIT,  1'b1);
        send("upd.rd",  4'd5, 32'h0001_3000, 2'b00, K_HIT,  1'b0);
        send("victim",  4'd6, 32'h0001_1000, 2'b00, K_HIT,  1'b1);

        // Held miss survives flush + refill race; refill is dropped
        bus.miss_ready_i = 1'b0;
        send("held", 4'd9, 32'h0003_0000, 2'b00, K_MISS, 1'b0);
        held = {4'd9, 32'h0003_0000, 2'b00};
        flush        = 1'b1;
        refill_valid = 1'b1;
        refill_ppn   = 20'h00020;
        refill_perm  = 3'b111;
        step();
        flush        = 1'b0;
        refill_valid = 1'b0;
        chk("held.valid", 64'(bus.miss_valid_o), 64'd1);
        chk("held.data",  64'(bus.miss_data_o),  64'(held));
        bus.miss_ready_i = 1'b1;
        send("race",    4'd10, 32'h0002_0000, 2'b00, K_MISS, 1'b0);
        send("flushed", 4'd11, 32'h0001_2000, 2'b00, K_MISS, 1'b0);
        step();

        // Statistics
`ifdef MPT_PLB_STATS_EN
        chk("stats.hit",  64'(hit_count),  64'(exp_hits));
        chk("stats.miss", 64'(miss_count), 64'(exp_misses));
`else
        chk("stats.hit",  64'(hit_count),  64'd0);
        chk("stats.miss", 64'(miss_count), 64'd0);
`endif

        // Reset while a miss is held discards it; entries are cleared
        refill(20'h00005, 3'b111);
        bus.miss_ready_i = 1'b0;
        send("pre_rst", 4'd12, 32'h0004_0000, 2'b00, K_MISS, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst.miss_valid", 64'(bus.miss_valid_o), 64'd0);
        chk("midrst.miss_data",  64'(bus.miss_data_o),  64'd0);
        chk("midrst.miss_cnt",   64'(miss_count),       64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.miss_ready_i = 1'b1;
        step();
        chk("midrst.idle", 64'(bus.miss_valid_o), 64'd0);
        send("post_rst", 4'd13, 32'h0000_5000, 2'b00, K_MISS, 1'b0);
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
